ads41_lane_align: RTL and testbench

//  Multi-channel successor to the single-ADC capture top. It sits after the NCH deserialised ADS41 channels.
//  - Sweeps the shared IDELAY tap while the ADC drives its test pattern.
//  - Tracks the open eye per channel, then loads each channel's centre tap.
//  - Afterwards it forwards aligned data and overrange, qualified by valid.

---
 rtl/ads41_align_pkg.sv | 38 +++
 rtl/ads41_eye_tracker.sv | 63 ++++++
 rtl/ads41_lane_align.sv | 161 ++++++++++++++++
 tb/tb_ads41_lane_align.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads41_align_pkg.sv
// Shared types for the ADS41 multi-lane IDELAY alignment block:
// the training FSM state encoding, the tap-width helper and the per-lane
// eye tracker record.
package ads41_align_pkg;

  // Training sequence: IDLE -> SET_TAP -> SETTLE -> DWELL -> ... -> CENTER
  // -> LOAD -> LOAD_SETTLE -> DONE. LOAD_SETTLE is the settle wait after the
  // centre taps are loaded.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_TAP,
    S_SETTLE,
    S_DWELL,
    S_CENTER,
    S_LOAD,
    S_LOAD_SETTLE,
    S_DONE
  } state_t;

  function automatic int tap_w(input int ntaps);
    return (ntaps <= 2) ? 1 : $clog2(ntaps);
  endfunction

  // The sweep length is fixed here so that the tracker record widths and
  // the top-level tap counter always agree.
  localparam int NTAPS_DEF = 32;
  localparam int TRK_TAP_W = tap_w(NTAPS_DEF);
  localparam int TRK_LEN_W = TRK_TAP_W + 1;

  // Open run and best run found so far for one lane.
  typedef struct packed {
    logic [TRK_TAP_W-1:0] run_start;
    logic [TRK_LEN_W-1:0] run_len;
    logic [TRK_TAP_W-1:0] best_start;
    logic [TRK_LEN_W-1:0] best_len;
  } trk_t;

endpackage

// File: rtl/ads41_eye_tracker.sv
// Per-lane open-eye tracker. Accumulates the run of consecutive passing taps,
// keeps the earliest longest run, and on close produces the centre tap and
// the eye-wide-enough flag.
import ads41_align_pkg::*;

module ads41_eye_tracker #(
  parameter int MIN_EYE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 tap_strobe,
  input  logic                 tap_pass,
  input  logic                 close,
  input  logic [TRK_TAP_W-1:0] tap,
  output logic [TRK_TAP_W-1:0] centre,
  output logic                 ok
);

  trk_t                 trk_q;
  logic                 run_wins;
  logic [TRK_TAP_W-1:0] fin_start;
  logic [TRK_LEN_W-1:0] fin_len;

  // Strictly longer runs replace the best, so the earliest longest run wins.
  always_comb begin
    run_wins  = trk_q.run_len > trk_q.best_len;
    fin_start = run_wins ? trk_q.run_start : trk_q.best_start;
    fin_len   = run_wins ? trk_q.run_len   : trk_q.best_len;
  end

  // Run/best bookkeeping per tap, final centre computed on close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_q  <= '0;
      centre <= '0;
      ok     <= 1'b0;
    end else if (clear) begin
      trk_q  <= '0;
      centre <= '0;
      ok     <= 1'b0;
    end else if (tap_strobe) begin
      if (tap_pass) begin
        if (trk_q.run_len == '0) trk_q.run_start <= tap;
        trk_q.run_len <= trk_q.run_len + 1'b1;
      end else begin
        if (run_wins) begin
          trk_q.best_start <= trk_q.run_start;
          trk_q.best_len   <= trk_q.run_len;
        end
        trk_q.run_len <= '0;
      end
    end else if (close) begin
      // The run still open at the last tap is closed here; no wrap to tap 0.
      trk_q.best_start <= fin_start;
      trk_q.best_len   <= fin_len;
      trk_q.run_len    <= '0;
      centre           <= (fin_len == '0) ? '0 : fin_start + TRK_TAP_W'(fin_len >> 1);
      ok               <= fin_len >= TRK_LEN_W'(MIN_EYE);
    end
  end

endmodule

// File: rtl/ads41_lane_align.sv
// ADS41 multi-channel lane alignment: sweeps the shared IDELAY tap while the
// ADC drives its test pattern, finds each lane's eye centre, loads it, then
// forwards registered data/overrange qualified by valid.
// Optional feature macro: ADS41_ALIGN_OVRCNT_EN adds per-lane saturating
// overrange counters (ovr_cnt) counted while trained.
//
// Handshake: start is a single-cycle request honoured only when the block is
// idle or done (busy low); valid rises with the first registered DONE-state
// sample and stays high until the next accepted start or rst.
import ads41_align_pkg::*;

module ads41_lane_align #(
  parameter int               NCH     = 4,
  parameter int               NBITS   = 12,
  parameter int               SETTLE  = 8,
  parameter int               DWELL   = 256,
  parameter int               MIN_EYE = 4,
  parameter logic [NBITS-1:0] PATTERN = 12'hA5C,
  localparam int              NTAPS   = NTAPS_DEF,
  localparam int              TAP_W   = TRK_TAP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NCH*NBITS-1:0]   d_in,
  input  logic [NCH-1:0]         ovr_in,
  output logic [NCH-1:0]         idelay_load,
  output logic [NCH*TAP_W-1:0]   idelay_val,
  output logic                   busy,
  output logic                   done,
  output logic [NCH-1:0]         lane_ok,
  output logic [NCH*NBITS-1:0]   d_out,
  output logic [NCH-1:0]         ovr_out,
  output logic                   valid
`ifdef ADS41_ALIGN_OVRCNT_EN
 ,output logic [NCH*16-1:0]      ovr_cnt
`endif
);

  localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NCH-1:0]     pass_q;
  logic [NCH-1:0]     match;
  logic               start_ok;
  logic               tap_strobe;
  logic               close;
  logic               use_centre;
  logic [TAP_W-1:0]   centre [NCH];

  // Next-state logic and single-cycle strobes to the trackers.
  always_comb begin
    state_d    = state_q;
    tap_strobe = 1'b0;
    close      = 1'b0;
    start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SET_TAP;
      S_SET_TAP:      state_d = S_SETTLE;
      S_SETTLE:       if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_DWELL;
      S_DWELL: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          tap_strobe = 1'b1;
          state_d    = (tap_q == TAP_W'(NTAPS - 1)) ? S_CENTER : S_SET_TAP;
        end
      end
      S_CENTER: begin
        close   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD:        state_d = S_LOAD_SETTLE;
      S_LOAD_SETTLE: if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_DONE;
      default:       state_d = S_IDLE;
    endcase
  end

  // State register, tap counter, settle/dwell counter, per-tap pass latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) tap_q <= '0;
      else if (tap_strobe && (state_d == S_SET_TAP)) tap_q <= tap_q + 1'b1;
      if (state_d != state_q) cnt_q <= '0;
      else if ((state_q == S_SETTLE) || (state_q == S_DWELL) || (state_q == S_LOAD_SETTLE))
        cnt_q <= cnt_q + 1'b1;
      // A lane passes a tap only if every dwell cycle matched.
      if (state_q == S_DWELL) pass_q <= pass_q & match;
      else                    pass_q <= '1;
    end
  end

  // Pattern compare per lane and the tap/centre values presented to IDELAY.
  always_comb begin
    use_centre  = (state_q == S_LOAD) || (state_q == S_LOAD_SETTLE) || (state_q == S_DONE);
    idelay_load = ((state_q == S_SET_TAP) || (state_q == S_LOAD)) ? '1 : '0;
    busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    done        = (state_q == S_DONE);
    match       = '0;
    idelay_val  = '0;
    for (int c = 0; c < NCH; c++) begin
      match[c] = (d_in[c*NBITS +: NBITS] == PATTERN);
      idelay_val[c*TAP_W +: TAP_W] = use_centre ? centre[c] : tap_q;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    ads41_eye_tracker #(.MIN_EYE(MIN_EYE)) u_trk (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_ok),
      .tap_strobe (tap_strobe),
      .tap_pass   (pass_q[c] & match[c]),
      .close      (close),
      .tap        (tap_q),
      .centre     (centre[c]),
      .ok         (lane_ok[c])
    );
  end

  // Datapath registers: pass-through only while trained, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out   <= '0;
      ovr_out <= '0;
      valid   <= 1'b0;
    end else if ((state_q == S_DONE) && !start) begin
      d_out   <= d_in;
      ovr_out <= ovr_in;
      valid   <= 1'b1;
    end else begin
      d_out   <= '0;
      ovr_out <= '0;
      valid   <= 1'b0;
    end
  end

`ifdef ADS41_ALIGN_OVRCNT_EN
  // Saturating per-lane overrange cycle counters, counted alongside ovr_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_cnt <= '0;
    end else if (start_ok) begin
      ovr_cnt <= '0;
    end else if (state_q == S_DONE) begin
      for (int c = 0; c < NCH; c++) begin
        if (ovr_in[c] && (ovr_cnt[c*16 +: 16] != 16'hFFFF))
          ovr_cnt[c*16 +: 16] <= ovr_cnt[c*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ads41_lane_align.sv
// Bench for ads41_lane_align: an ADC/IDELAY eye model drives d_in from the
// lane's currently loaded tap; expected centres/lane_ok are computed from the
// eye masks and queued at start; a monitor pops them at the centre load.
module tb_ads41_lane_align;

  localparam int NCH = 4, NBITS = 12, NTAPS = 32, TAP_W = 5;
  localparam int SETTLE = 8, DWELL = 32, MIN_EYE = 4;
  localparam logic [NBITS-1:0] PATTERN = 12'hA5C;
  localparam int EXP_W = NCH*TAP_W + NCH;
  localparam int BUDGET = 3000;
  localparam logic [NCH-1:0] ALL1 = '1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [NCH*NBITS-1:0] d_in;
  logic [NCH-1:0]       ovr_in;
  logic [NCH-1:0]       idelay_load;
  logic [NCH*TAP_W-1:0] idelay_val;
  logic                 busy, done, valid;
  logic [NCH-1:0]       lane_ok, ovr_out;
  logic [NCH*NBITS-1:0] d_out;
`ifdef ADS41_ALIGN_OVRCNT_EN
  logic [NCH*16-1:0]    ovr_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [NTAPS-1:0] eye [NCH];
  int  glitch_lane = -1;
  int  glitch_tap  = -1;
  bit  phase = 1'b0;
  int  load_idx = 0;
  int  sweeps_seen = 0;
  int  sweeps_issued = 0;
  bit  force_ovr1 = 1'b0;

  ads41_lane_align #(.NCH(NCH), .NBITS(NBITS), .SETTLE(SETTLE), .DWELL(DWELL),
                     .MIN_EYE(MIN_EYE), .PATTERN(PATTERN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .d_in        (d_in),
    .ovr_in      (ovr_in),
    .idelay_load (idelay_load),
    .idelay_val  (idelay_val),
    .busy        (busy),
    .done        (done),
    .lane_ok     (lane_ok),
    .d_out       (d_out),
    .ovr_out     (ovr_out),
    .valid       (valid)
`ifdef ADS41_ALIGN_OVRCNT_EN
   ,.ovr_cnt     (ovr_cnt)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: earliest longest run of passing taps, no wrap.
  function automatic void ref_eye(input logic [NTAPS-1:0] m, output int ctr, output bit ok);
    int bs, bl, s, l;
    bs = 0; bl = 0; s = 0; l = 0;
    for (int t = 0; t <= NTAPS; t++) begin
      if (t < NTAPS && m[t]) begin
        if (l == 0) s = t;
        l++;
      end else begin
        if (l > bl) begin bl = l; bs = s; end
        l = 0;
      end
    end
    ctr = (bl == 0) ? 0 : bs + bl / 2;
    ok  = (bl >= MIN_EYE);
  endfunction

  function automatic logic [NTAPS-1:0] win(input int lo, input int hi);
    logic [NTAPS-1:0] m;
    m = '0;
    for (int t = lo; t <= hi && t < NTAPS; t++) m[t] = 1'b1;
    return m;
  endfunction

  function automatic logic [NTAPS-1:0] rand_eye();
    int lo;
    case ($urandom_range(0, 2))
      0: return $urandom;
      1: begin lo = $urandom_range(0, 31); return win(lo, lo + $urandom_range(0, 11)); end
      default: begin
        lo = $urandom_range(0, 12);
        return win(lo, lo + $urandom_range(0, 6)) | win(lo + 14, lo + 14 + $urandom_range(0, 6));
      end
    endcase
  endfunction

  task automatic push_expect();
    logic [EXP_W-1:0] e;
    logic [NTAPS-1:0] m;
    int ctr;
    bit ok;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      m = eye[c];
      if (c == glitch_lane) m[glitch_tap] = 1'b0;
      ref_eye(m, ctr, ok);
      e[c*TAP_W +: TAP_W] = TAP_W'(ctr);
      e[NCH*TAP_W + c]    = ok;
    end
    exp_q.push_back(e);
  endtask

  // Driver tasks
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < BUDGET && !phase; i++) @(negedge clk);
    if (!phase) fail_now(name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load"},  idelay_load, 0);
    check({tag, "_val"},   idelay_val, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_ok"},    lane_ok, 0);
    check({tag, "_dout"},  d_out, 0);
    check({tag, "_ovr"},   ovr_out, 0);
    check({tag, "_valid"}, valid, 0);
`ifdef ADS41_ALIGN_OVRCNT_EN
    check({tag, "_ovrcnt"}, ovr_cnt, 0);
`endif
  endtask

  task automatic train(input logic [NTAPS-1:0] e0, input logic [NTAPS-1:0] e1,
                       input logic [NTAPS-1:0] e2, input logic [NTAPS-1:0] e3,
                       input int gl, input int gt, input bit poke_busy);
    eye[0] = e0; eye[1] = e1; eye[2] = e2; eye[3] = e3;
    glitch_lane = gl; glitch_tap = gt;
    push_expect();
    sweeps_issued++;
    pulse_start();
    if (poke_busy) begin
      repeat (200) @(posedge clk);
      pulse_start();
    end
    wait_done("train_timeout");
    repeat (20) @(posedge clk);
  endtask

  // ADC + IDELAY model: pattern only when the lane's loaded tap is in its
  // eye and the settle window after the last load has elapsed.
  initial begin
    int since;
    logic [TAP_W-1:0] cur [NCH];
    logic [NBITS-1:0] w;
    since = 1000;
    for (int c = 0; c < NCH; c++) cur[c] = '0;
    d_in = '0;
    ovr_in = '0;
    forever begin
      @(posedge clk); #2;
      if (rst) since = 1000;
      else if (idelay_load != '0) begin
        for (int c = 0; c < NCH; c++)
          if (idelay_load[c]) cur[c] = idelay_val[c*TAP_W +: TAP_W];
        since = 0;
      end else if (since < 1000) since++;
      for (int c = 0; c < NCH; c++) begin
        w = NBITS'($urandom_range(0, 4095));
        if (!phase) begin
          if (w == PATTERN) w = w ^ 12'h001;
          if (since > SETTLE && since < 1000 && eye[c][cur[c]] &&
              !(c == glitch_lane && int'(cur[c]) == glitch_tap && since == SETTLE + 17))
            w = PATTERN;
        end
        d_in[c*NBITS +: NBITS] = w;
      end
      ovr_in = NCH'($urandom_range(0, 15));
      if (force_ovr1) ovr_in[1] = 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    int wcnt;
    bit waiting, p_phase, p_start, ev;
    logic [EXP_W-1:0] cur_exp;
    logic [NCH-1:0] exp_ok;
    logic [NCH*NBITS-1:0] p_d;
    logic [NCH-1:0] p_o;
    logic [TAP_W-1:0] ti;
    wcnt = 0; waiting = 0; p_phase = 0; p_start = 0;
    exp_ok = '0; p_d = '0; p_o = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        load_idx = 0; waiting = 0; phase = 0; p_phase = 0; p_start = 0;
        continue;
      end
      ev = p_phase && !p_start;
      check("valid", valid, ev);
      check("d_out", d_out, ev ? p_d : '0);
      check("ovr_out", ovr_out, ev ? p_o : '0);
      if (p_phase && p_start) begin
        check("restart_lane_ok", lane_ok, 0);
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
      end
      if (idelay_load != '0) begin
        if (waiting) check("load_after_centre", idelay_load, 0);
        else if (load_idx < NTAPS) begin
          ti = load_idx[TAP_W-1:0];
          check("sweep_load", idelay_load, ALL1);
          check("sweep_tap", idelay_val, {NCH{ti}});
          load_idx++;
        end else begin
          check("centre_load", idelay_load, ALL1);
          if (exp_q.size() == 0) fail_now("unexpected_training");
          else begin
            cur_exp = exp_q.pop_front();
            check("centre_val", idelay_val, cur_exp[NCH*TAP_W-1:0]);
            exp_ok = cur_exp[EXP_W-1 -: NCH];
          end
          load_idx = 0; waiting = 1; wcnt = 0;
          sweeps_seen++;
        end
      end else if (waiting) begin
        wcnt++;
        if (wcnt == SETTLE) begin
          check("busy_pre_done", busy, 1);
          check("done_pre_done", done, 0);
        end
        if (wcnt == SETTLE + 1) begin
          check("done", done, 1);
          check("busy_done", busy, 0);
          check("lane_ok", lane_ok, exp_ok);
          waiting = 0;
          phase = 1;
        end
      end
      p_phase = phase;
      p_start = start;
      p_d = d_in;
      p_o = ovr_in;
      if (phase && start) phase = 0;
    end
  end

  // Stimulus sequence and final report
  initial begin
    logic [NTAPS-1:0] mid_a, mid_b, eq2;
    for (int c = 0; c < NCH; c++) eye[c] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    mid_a = win(10, 17);
    mid_b = win(4, 9) | win(20, 29);
    eq2   = win(2, 5) | win(12, 15);
    // Distinct centres per lane (14 / 25) and all lanes ok
    train(mid_a, mid_b, mid_b, mid_b, -1, -1, 1'b0);
    // Lane 2 never sees the pattern
    train(mid_a, mid_b, '0, mid_b, -1, -1, 1'b0);
    // Equal runs (earliest wins), glitch splits lane0's first run, run to last tap,
    // plus a start while busy which must be ignored
    train(eq2, win(28, 31), eq2, rand_eye(), 0, 3, 1'b1);
    // Randomised eyes
    for (int k = 0; k < 3; k++)
      train(rand_eye(), rand_eye(), rand_eye(), rand_eye(), -1, -1, 1'b0);

    // Reset in the middle of the dwell at tap 7
    eye[0] = rand_eye(); eye[1] = rand_eye(); eye[2] = rand_eye(); eye[3] = rand_eye();
    glitch_lane = -1;
    push_expect();
    pulse_start();
    for (int i = 0; i < BUDGET && load_idx != 8; i++) @(negedge clk);
    if (load_idx != 8) fail_now("tap7_timeout");
    repeat (SETTLE + 10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_rst");

    train(rand_eye(), mid_a, rand_eye(), win(28, 31), -1, -1, 1'b0);

`ifdef ADS41_ALIGN_OVRCNT_EN
    force_ovr1 = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("ovr_cnt_sat", ovr_cnt[16 +: 16], 16'hFFFF);
    force_ovr1 = 1'b0;
    eye[0] = mid_a; eye[1] = mid_b; eye[2] = mid_b; eye[3] = mid_b;
    push_expect();
    sweeps_issued++;
    pulse_start();
    @(negedge clk);
    check("ovr_cnt_clear", ovr_cnt, 0);
    wait_done("ovr_train_timeout");
`endif

    repeat (5) @(posedge clk);
    check("sweep_count", sweeps_seen, sweeps_issued);
    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
